// File: rtl/noc_types.sv
// -----------------------------------------------------------------------------
// noc_types
//   Shared constants and types for the EXU divide NoC link.
//   - Flit type encodings (HEAD / BODY / TAIL).
//   - Position and width of the destination address in a HEAD flit.
//   - Node address of the divider wrapper.
//   - The divide request packet types and the serialised payload width.
//   - A helper that computes how many flits a payload occupies.
// -----------------------------------------------------------------------------
package noc_types;

    // Flit type encodings carried on flit_type.
    localparam logic [1:0] FLIT_BODY = 2'b00;
    localparam logic [1:0] FLIT_HEAD = 2'b01;
    localparam logic [1:0] FLIT_TAIL = 2'b10;

    // Destination address field inside the data word of a HEAD flit.
    localparam int HEAD_ADDR_LSB  = 0;
    localparam int HEAD_ADDR_BITS = 8;

    // Node address of the divider wrapper on the NoC.
    localparam logic [HEAD_ADDR_BITS-1:0] POS_DIV_WRAPPER = 8'h0C;

    // Divide control fields, valid in the MSB.
    typedef struct packed {
        logic valid;
        logic unsign;
        logic rem;
    } el2_div_pkt_t;

    // Payload as it travels over the link; divisor sits in the LSBs.
    typedef struct packed {
        el2_div_pkt_t dp;
        logic         cancel;
        logic [31:0]  dividend;
        logic [31:0]  divisor;
    } div_payload_t;

    localparam int PAYLOAD_BITS = $bits(div_payload_t);

    // Number of flits needed to carry 'bits' payload bits, rounded up.
    function automatic int flit_count(input int bits, input int flit_bits);
        return (bits + flit_bits - 1) / flit_bits;
    endfunction

endpackage : noc_types

// File: rtl/noc_serial_receiver.sv
// -----------------------------------------------------------------------------
// noc_serial_receiver
//   Generic deserialiser for a HEAD / BODY... / TAIL flit stream. A packet
//   addressed to NODE_ADDR is assembled most-significant chunk first, the last
//   chunk arriving on the TAIL flit, and is then held on pkt_data with
//   pkt_valid until pkt_ready. Packets for other nodes are consumed silently.
//   Protocol violations produce a registered one-cycle err pulse.
//
// Ports
//   clk, rst_l             clock, asynchronous active-low reset
//   flit_valid/type/data   incoming flit
//   flit_ready             flit accepted when flit_valid & flit_ready
//   flush                  abandon any partial packet or held packet
//   pkt_valid / pkt_ready  held packet handshake
//   pkt_data               assembled packet, pad bits stripped
//   err                    one-cycle protocol error pulse
// -----------------------------------------------------------------------------
module noc_serial_receiver
    import noc_types::*;
#(
    parameter int                        FLIT_DATA_BITS = 32,
    parameter int                        PACKET_BITS    = 68,
    parameter int                        PADDING_BITS   = 28,
    parameter logic [HEAD_ADDR_BITS-1:0] NODE_ADDR      = POS_DIV_WRAPPER
) (
    input  logic                      clk,
    input  logic                      rst_l,
    input  logic                      flit_valid,
    input  logic [1:0]                flit_type,
    input  logic [FLIT_DATA_BITS-1:0] flit_data,
    output logic                      flit_ready,
    input  logic                      flush,
    output logic                      pkt_valid,
    input  logic                      pkt_ready,
    output logic [PACKET_BITS-1:0]    pkt_data,
    output logic                      err
);

    localparam int WORD_BITS = PACKET_BITS + PADDING_BITS;
    localparam int NFLITS    = WORD_BITS / FLIT_DATA_BITS;
    // Chunks delivered on BODY flits; the final chunk comes on TAIL.
    // At least two flits per packet are assumed.
    localparam int ASM_BITS  = (NFLITS - 1) * FLIT_DATA_BITS;
    localparam int CNT_W     = $clog2(NFLITS + 1);
    localparam logic [CNT_W-1:0] LAST_BODY = CNT_W'(NFLITS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BODY = 2'd1,
        DROP = 2'd2,
        HOLD = 2'd3
    } state_t;

    state_t               state, state_n;
    logic [CNT_W-1:0]     cnt, cnt_n;
    logic                 err_n;
    logic                 shift_en;
    logic                 latch_en;
    logic                 out_of_reset;
    logic [ASM_BITS-1:0]  asm_q;
    logic [PACKET_BITS-1:0] pkt_q;

    logic handshake;
    logic is_head;
    logic is_tail;
    logic addr_hit;

    assign handshake = flit_valid & flit_ready;
    assign is_head   = (flit_type == FLIT_HEAD);
    assign is_tail   = (flit_type == FLIT_TAIL);
    assign addr_hit  = (flit_data[HEAD_ADDR_LSB +: HEAD_ADDR_BITS] == NODE_ADDR);

    // Held low through reset by out_of_reset; no flits while a packet is held.
    assign flit_ready = out_of_reset & (state != HOLD);
    assign pkt_valid  = (state == HOLD);
    assign pkt_data   = pkt_q;

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state        <= IDLE;
            cnt          <= '0;
            err          <= 1'b0;
            out_of_reset <= 1'b0;
        end else begin
            state        <= state_n;
            cnt          <= cnt_n;
            err          <= err_n;
            out_of_reset <= 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    // NOTE: every output of this block gets a default first so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        err_n    = 1'b0;
        shift_en = 1'b0;
        latch_en = 1'b0;

        if (flush) begin
            state_n = IDLE;
            cnt_n   = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (handshake) begin
                        if (is_head) begin
                            state_n = addr_hit ? BODY : DROP;
                            cnt_n   = '0;
                        end else begin
                            err_n = 1'b1;
                        end
                    end
                end

                BODY: begin
                    if (handshake) begin
                        if (is_head) begin
                            // Unexpected HEAD: flag it, then restart on it.
                            err_n   = 1'b1;
                            state_n = addr_hit ? BODY : DROP;
                            cnt_n   = '0;
                        end else if (is_tail) begin
                            if (cnt == LAST_BODY) begin
                                latch_en = 1'b1;
                                state_n  = HOLD;
                            end else begin
                                err_n   = 1'b1;
                                state_n = IDLE;
                            end
                        end else if (cnt == LAST_BODY) begin
                            // Overrun: the counter never wraps, the rest of
                            // the packet is discarded.
                            err_n   = 1'b1;
                            state_n = DROP;
                        end else begin
                            shift_en = 1'b1;
                            cnt_n    = cnt + CNT_W'(1);
                        end
                    end
                end

                DROP: begin
                    if (handshake && is_tail) begin
                        state_n = IDLE;
                    end
                end

                HOLD: begin
                    if (pkt_ready) begin
                        state_n = IDLE;
                    end
                end

                default: state_n = IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Datapath: assembly shift register and held packet
    // ------------------------------------------------------------------------
    // NOTE: the data registers are reset as well, so the request fields read
    // as zero after reset rather than as whatever the flops powered up with.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            asm_q <= '0;
            pkt_q <= '0;
        end else begin
            if (shift_en) begin
                // Older chunks move up; the newest lands in the LSBs.
                asm_q <= ASM_BITS'({asm_q, flit_data});
            end
            if (latch_en) begin
                // Truncation drops the zero pad above the packet.
                pkt_q <= PACKET_BITS'({asm_q, flit_data});
            end
        end
    end

endmodule : noc_serial_receiver

// File: rtl/el2_exu_div_receiver.sv
// -----------------------------------------------------------------------------
// el2_exu_div_receiver
//   Receive side of the EXU divide NoC link. Accepts the flit stream sent
//   toward the divider wrapper, checks the destination address, deserialises
//   {dp, cancel, dividend, divisor} and presents one registered divide request
//   with backpressure to the divider.
//
// Ports
//   clk, rst_l                 clock, asynchronous active-low reset
//   flit_valid/type/data       NoC flit input
//   flit_ready                 flit accepted when flit_valid & flit_ready
//   flush                      drop any partial packet and any held request
//   req_valid / req_ready      divide request handshake
//   dp, cancel                 request control fields
//   dividend, divisor          operands
//   err                        one-cycle protocol error pulse
// -----------------------------------------------------------------------------
module el2_exu_div_receiver
    import noc_types::*;
#(
    parameter int                        FLIT_DATA_BITS = 32,
    parameter logic [HEAD_ADDR_BITS-1:0] NODE_ADDR      = POS_DIV_WRAPPER,
    parameter int                        PAYLOAD_BITS   = noc_types::PAYLOAD_BITS
) (
    input  logic                      clk,
    input  logic                      rst_l,
    input  logic                      flit_valid,
    input  logic [1:0]                flit_type,
    input  logic [FLIT_DATA_BITS-1:0] flit_data,
    output logic                      flit_ready,
    input  logic                      flush,
    output logic                      req_valid,
    input  logic                      req_ready,
    output el2_div_pkt_t              dp,
    output logic                      cancel,
    output logic [31:0]               dividend,
    output logic [31:0]               divisor,
    output logic                      err
);

    localparam int NFLITS       = flit_count(PAYLOAD_BITS, FLIT_DATA_BITS);
    localparam int PADDING_BITS = NFLITS * FLIT_DATA_BITS - PAYLOAD_BITS;

    logic [PAYLOAD_BITS-1:0] pkt_data;
    div_payload_t            payload;

    noc_serial_receiver #(
        .FLIT_DATA_BITS (FLIT_DATA_BITS),
        .PACKET_BITS    (PAYLOAD_BITS),
        .PADDING_BITS   (PADDING_BITS),
        .NODE_ADDR      (NODE_ADDR)
    ) u_rx (
        .clk        (clk),
        .rst_l      (rst_l),
        .flit_valid (flit_valid),
        .flit_type  (flit_type),
        .flit_data  (flit_data),
        .flit_ready (flit_ready),
        .flush      (flush),
        .pkt_valid  (req_valid),
        .pkt_ready  (req_ready),
        .pkt_data   (pkt_data),
        .err        (err)
    );

    // Field unpacking only; the held packet register already keeps the
    // request stable while req_valid is high.
    assign payload  = pkt_data;
    assign dp       = payload.dp;
    assign cancel   = payload.cancel;
    assign dividend = payload.dividend;
    assign divisor  = payload.divisor;

endmodule : el2_exu_div_receiver

// File: doc/el2_exu_div_receiver.md
# el2_exu_div_receiver

Receive side of the EXU divide NoC link. It accepts the flit stream that the divide sender emits toward `POS_DIV_WRAPPER` and checks the destination address. It deserialises the payload `{dp, cancel, dividend, divisor}` and presents one registered divide request to the divider wrapper, with backpressure. It sits between the NoC output port of the divider node and the `el2_exu_div` request inputs.

## Interface
Parameters:
- `FLIT_DATA_BITS`, 32: data bits per flit.
- `NODE_ADDR`, `` `POS_DIV_WRAPPER ``: own node address, 8 bits.
- `PAYLOAD_BITS`, 68: `$bits(el2_div_pkt_t)` + 1 + 32 + 32.

Ports:
- `clk`  in  1  clock.
- `rst_l`  in  1  reset. One clock; reset is asynchronous and active-low.
- `flit_valid`  in  1  flit present.
- `flit_type`  in  2  flit type: HEAD=2'b01, BODY=2'b00, TAIL=2'b10.
- `flit_data`  in  FLIT_DATA_BITS  flit data. On a HEAD flit, bits [7:0] are the destination address.
- `flit_ready`  out  1  flit accepted this cycle when `flit_valid & flit_ready`.
- `flush`  in  1  discard any partial packet and any held request.
- `req_valid`  out  1  divide request held.
- `req_ready`  in  1  divider accepts the request.
- `dp`  out  el2_div_pkt_t  request fields {valid, unsign, rem}.
- `cancel`  out  1  cancel bit from the packet.
- `dividend`  out  32  numerator.
- `divisor`  out  32  denominator.
- `err`  out  1  one-cycle pulse on a protocol error.

## Operation
- `NFLITS` = ceil(PAYLOAD_BITS / FLIT_DATA_BITS); 3 at default.
- The payload word is NFLITS*FLIT_DATA_BITS wide, laid out as {zero pad, dp, cancel, dividend, divisor}, with divisor in the LSBs.
- Body flits carry the payload most-significant chunk first. The last chunk arrives on the TAIL flit.
- FSM states: IDLE, BODY, DROP, HOLD.
- IDLE:
  - HEAD with address = NODE_ADDR → BODY, chunk counter cleared.
  - HEAD with any other address → DROP.
  - BODY or TAIL flit → discarded, `err` pulses, stay in IDLE.
- BODY:
  - BODY flit → shift the chunk into the assembly register, counter +1.
  - TAIL flit with counter = NFLITS-1 → latch the outputs, go to HOLD.
  - TAIL flit with a wrong count → `err` pulses, go to IDLE, nothing is delivered.
  - BODY flit when counter = NFLITS-1 (overrun) → `err` pulses, go to DROP.
  - HEAD flit → `err` pulses, then handled as a fresh HEAD from IDLE (restart).
- DROP: consume flits until TAIL, then go to IDLE. No `err` pulse for a foreign address.
- HOLD: `req_valid` = 1 and the outputs are stable. On `req_ready` → IDLE.
- `flit_ready` = 1 in IDLE, BODY and DROP; 0 in HOLD.
- A packet with `cancel` = 1 is delivered like any other packet. The divider interprets it.
- `flush` has priority over every transition. It forces IDLE, clears the counter and drops `req_valid`. It does not pulse `err`.

## Timing
- Reset: `flit_ready` = 0 while `rst_l` is low. After release, `flit_ready` = 1. `req_valid`, `err`, `dp`, `cancel`, `dividend` and `divisor` all reset to 0. State is IDLE.
- Latency: `req_valid` rises on the cycle after the TAIL handshake. Minimum packet-to-request time is NFLITS+1 flit cycles plus 1.
- HOLD exit: `flit_ready` returns high on the cycle after the `req_ready` handshake. There is no same-cycle bypass.
- `err` is registered and asserts on the cycle after the offending handshake.
- `rst_l` assertion mid-packet or mid-HOLD clears everything immediately (asynchronous reset).
- The counter never wraps: an overrun goes to DROP.

## Structure
- Shared constants go in `noc_types`: flit type encodings, head address field position, and `PAYLOAD_BITS`.
- The FSM state enum stays local to this module.
- One sub-module, `noc_serial_receiver`, is natural. It is the generic shift/count/FSM deserialiser parameterised on PACKET_BITS/PADDING_BITS. It mirrors the existing serial sender, and this block adds only the field unpacking.

## Test plan
- Single request, FLIT_DATA_BITS=32. Send HEAD(0x..NODE_ADDR), 0x00000008, 0x00000064, TAIL 0x00000007, with `req_ready` = 1. The next cycle shows `req_valid` = 1, dp = {1,0,0}, cancel = 0, dividend = 100, divisor = 7. `err` stays 0.
- Backpressure: same packet with `req_ready` = 0 for 5 cycles. `req_valid` and the outputs stay stable and `flit_ready` = 0. A second packet sent meanwhile is not consumed until 1 cycle after the handshake.
- Foreign address: HEAD with address NODE_ADDR+1, followed by 3 flits. No `req_valid` and no `err`. A following valid packet is delivered normally.
- Protocol errors:
  - A BODY flit in IDLE gives an `err` pulse.
  - A TAIL flit after 1 body flit gives an `err` pulse and no request.
  - A HEAD flit mid-packet gives an `err` pulse, and the restarted packet is delivered correctly.
- `flush` asserted after the 2nd flit: state returns to IDLE, and the remaining flits count as errors until the next HEAD. `flush` in HOLD drops `req_valid` the next cycle.
- `rst_l` low during BODY: all outputs go to 0 immediately. After release, a full packet is delivered correctly.
